// File: rtl/muller_c_pkg.sv
// Shared constants and next-state rule for the clocked Muller C-element bank.
package muller_c_pkg;

    localparam int unsigned CHANNELS_DEF    = 4;
    localparam int unsigned N_IN_DEF        = 3;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned CNT_W_DEF       = 8;

    // C-element rule: a rise or fall condition alone drives the output; both or neither hold it.
    function automatic logic cel_next(input logic cur, input logic rise_ok, input logic fall_ok);
        logic nxt;
        nxt = cur;
        if (rise_ok && !fall_ok) begin
            nxt = 1'b1;
        end else if (fall_ok && !rise_ok) begin
            nxt = 1'b0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/muller_c_cell.sv
// One clocked C-element channel: input synchroniser, state flop, edge pulses, saturating counter.
module muller_c_cell
    import muller_c_pkg::*;
#(
    parameter int unsigned N_IN        = N_IN_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  in_data,
    input  logic [N_IN-1:0]  plus_mask,
    input  logic [N_IN-1:0]  minus_mask,
    input  logic             en,
    input  logic             clr_cnt,
    output logic             c_out,
    output logic             c_rise,
    output logic             c_fall,
    output logic [CNT_W-1:0] trans_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_IN-1:0] sync_q [SYNC_STAGES];
    logic [N_IN-1:0] s;
    logic            rise_ok_c;
    logic            fall_ok_c;
    logic            next_c;

    assign s = sync_q[SYNC_STAGES-1];

    // Input synchroniser chain; keeps sampling regardless of en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= in_data;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Masked-off inputs are forced true so they drop out of the AND; empty sets evaluate to 1.
    always_comb begin
        rise_ok_c = &(s | minus_mask);
        fall_ok_c = &(~s | plus_mask);
        next_c    = cel_next(c_out, rise_ok_c, fall_ok_c);
    end

    // Element state and one-cycle edge pulses, frozen while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_out  <= RESET_VAL;
            c_rise <= 1'b0;
            c_fall <= 1'b0;
        end else if (en) begin
            c_out  <= next_c;
            c_rise <= next_c & ~c_out;
            c_fall <= ~next_c & c_out;
        end else begin
            c_rise <= 1'b0;
            c_fall <= 1'b0;
        end
    end

    // Saturating transition counter; clear wins over a coincident transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trans_cnt <= '0;
        end else if (clr_cnt) begin
            trans_cnt <= '0;
        end else if (en && (next_c != c_out) && (trans_cnt != CNT_MAX)) begin
            trans_cnt <= trans_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/muller_c_array.sv
// Bank of CHANNELS independent clocked Muller C-elements sharing masks, enable and counter clear.
module muller_c_array
    import muller_c_pkg::*;
#(
    parameter int unsigned CHANNELS    = CHANNELS_DEF,
    parameter int unsigned N_IN        = N_IN_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*N_IN-1:0]  in_data,
    input  logic [N_IN-1:0]           plus_mask,
    input  logic [N_IN-1:0]           minus_mask,
    input  logic                      en,
    input  logic                      clr_cnt,
    output logic [CHANNELS-1:0]       c_out,
    output logic [CHANNELS-1:0]       c_rise,
    output logic [CHANNELS-1:0]       c_fall,
    output logic                      all_equal,
    output logic [CHANNELS*CNT_W-1:0] trans_cnt
);

    // One cell per channel; channels share nothing but the control inputs.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_cell
        muller_c_cell #(
            .N_IN        (N_IN),
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .RESET_VAL   (RESET_VAL)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .in_data    (in_data[c*N_IN +: N_IN]),
            .plus_mask  (plus_mask),
            .minus_mask (minus_mask),
            .en         (en),
            .clr_cnt    (clr_cnt),
            .c_out      (c_out[c]),
            .c_rise     (c_rise[c]),
            .c_fall     (c_fall[c]),
            .trans_cnt  (trans_cnt[c*CNT_W +: CNT_W])
        );
    end

    // Combinational agreement flag across all element outputs.
    assign all_equal = (&c_out) | ~(|c_out);

endmodule

// File: doc/muller_c_array.md
# muller_c_array

Parametrised bank of clocked Muller C-elements: the next generation of the single-channel `muller_c_proj` element. It has CHANNELS independent elements of N_IN inputs each, with per-input asymmetric (plus/minus) participation, input synchronisers, rise/fall event pulses and saturating per-channel transition counters. It sits behind the project's `io_in` pads as the handshake-completion core of the async test project. It is clocked so that formal cover traces and Caravel logic-analyser readback stay deterministic.

## Interface
- CHANNELS, 4, number of independent C-elements
- N_IN, 3, inputs per element (≥2)
- SYNC_STAGES, 2, synchroniser flops per input (≥1)
- CNT_W, 8, transition counter width per channel
- RESET_VAL, 1'b0, reset value of every element output

- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  CHANNELS*N_IN  element inputs, channel c at [c*N_IN +: N_IN], asynchronous to clk
- plus_mask  in  N_IN  input i only gates rising (ignored for fall)
- minus_mask  in  N_IN  input i only gates falling (ignored for rise)
- en  in  1  1 = elements evaluate; 0 = outputs and counters hold
- clr_cnt  in  1  synchronous clear of all counters
- c_out  out  CHANNELS  element outputs
- c_rise  out  CHANNELS  one-cycle pulse, c_out[c] went 0→1 this cycle
- c_fall  out  CHANNELS  one-cycle pulse, c_out[c] went 1→0 this cycle
- all_equal  out  1  all c_out bits identical
- trans_cnt  out  CHANNELS*CNT_W  saturating count of transitions per channel

## Operation
- Each input bit passes through SYNC_STAGES flops; s[c][i] is the final stage. Masks and en are used directly and are quasi-static.
- Rise set R = inputs with minus_mask[i]=0; fall set F = inputs with plus_mask[i]=0. An input with both mask bits set is ignored.
- rise_ok[c] = AND of s[c][i] over R (1 if R is empty); fall_ok[c] = AND of ~s[c][i] over F (1 if F is empty).
- Next state when en=1: rise_ok & ~fall_ok → 1; fall_ok & ~rise_ok → 0; both or neither → hold. A simultaneous rise/fall condition always holds.
- When en=0: c_out holds, c_rise/c_fall are 0, counters hold, and synchronisers keep sampling.
- c_rise[c] = next&~cur and c_fall[c] = ~next&cur, registered alongside c_out. A pulse is never longer than 1 cycle.
- trans_cnt[c] increments on any c_rise/c_fall. It saturates at 2^CNT_W−1 and does not wrap. clr_cnt has priority: a clear coinciding with a transition yields 0.
- all_equal is combinational from c_out.

## Timing
- Reset (async assert, synchronous to clk deassert handled externally): synchronisers 0, c_out = {CHANNELS{RESET_VAL}}, c_rise = c_fall = 0, trans_cnt = 0, all_equal = 1.
- Reset mid-operation clears all state within the same cycle. Pulses in flight are dropped.
- Latency from an in_data change to c_out/pulse: SYNC_STAGES+1 rising edges (3 at default).
- A changed mask takes effect on the next edge with no synchronisation.
- An en 0→1 transition evaluates on that same edge.

## Structure
- Package `muller_c_pkg`: default parameter constants and a `cel_next()` function (cur, rise_ok, fall_ok → next) shared by RTL and formal wrapper.
- Sub-module `muller_c_cell`: one channel, containing the synchroniser, state flop, pulse flops and counter. The top generates CHANNELS instances and ORs nothing together except all_equal.
- Formal wrapper `muller_c_array_formal` maps `io_in` onto in_data/en for cover traces.

## Test plan
- Reset then defaults, in_data channel0 = 3'b111 → c_out[0]=1 and c_rise[0]=1 for exactly one cycle 3 cycles later; trans_cnt[0]=1; all_equal=0.
- Channel0 from 1, inputs 3'b011 → hold; then 3'b000 → c_out[0]=0 after 3 cycles, c_fall[0] pulse, trans_cnt[0]=2.
- plus_mask=3'b001, minus_mask=0, channel1 = 3'b110 while high → c_out[1] falls? No: bit0 ignored for fall, bits1-2 high → hold. Then 3'b001 → fall. Then 3'b110 → no rise (bit0 required low-only? bit0 in R) → hold.
- Both masks 3'b111 (R, F empty) → rise_ok=fall_ok=1 → all channels hold at RESET_VAL indefinitely, no pulses.
- CNT_W=2, toggle channel2 five times → trans_cnt[2] sticks at 3. Then clr_cnt coinciding with a sixth transition → 0 next cycle.
- Toggle channel3 with en=0 → no change. Raise en → update on the next edge. Assert rst mid-toggle → c_out=RESET_VAL, counters 0 immediately.
